// File: rtl/uart_target_framer.sv
// uart_target_framer: snapshots per-channel position/difference words on a
// vsync rising edge and streams them as one checksummed byte frame to a UART.
// Ports:
//   clk, reset (async, active-low)
//   uart_en    trigger enable
//   vsync_i    async frame sync, rising edge starts a frame
//   pos_i      CH_NUM packed position words
//   diff_i     CH_NUM packed difference words
//   tx_busy    byte transmitter busy
//   tx_data    byte to send
//   tx_en      one-cycle send strobe
//   frame_busy high while a frame is in progress
//   overrun    one-cycle pulse when a trigger is dropped
//   seq_o      sequence number of the last started frame
module uart_target_framer #(
  parameter int          CH_NUM = 2,
  parameter int          POS_W  = 43,
  parameter int          DIFF_W = 12,
  parameter logic [7:0]  HDR0   = 8'hA5,
  parameter logic [7:0]  HDR1   = 8'h5A
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_en,
  input  logic                       vsync_i,
  input  logic [CH_NUM*POS_W-1:0]    pos_i,
  input  logic [CH_NUM*DIFF_W-1:0]   diff_i,
  input  logic                       tx_busy,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  output logic                       frame_busy,
  output logic                       overrun,
  output logic [7:0]                 seq_o
);

  localparam int PB  = (POS_W + 7) / 8;
  localparam int DB  = (DIFF_W + 7) / 8;
  localparam int CB  = PB + DB;
  localparam int ND  = CH_NUM * CB;
  localparam int LEN = 5 + ND;
  localparam int IW  = $clog2(LEN + 1);
  localparam int SW  = ND * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t          state_q;
  logic            s1_q, s2_q, s3_q;
  logic [1:0]      rdy_q;
  logic            arm_q;
  logic [SW-1:0]   snap_q;
  logic [7:0]      sum_q;
  logic [7:0]      seq_q;
  logic [IW-1:0]   idx_q;
  logic [1:0]      to_q;
  logic [7:0]      txd_q;
  logic            txen_q;
  logic            fb_q;
  logic            ovr_q;

  logic            edge_w;
  logic            trig_w;
  logic            add_en;
  logic [IW-1:0]   didx;
  logic [7:0]      byte_d;

  // Data bytes laid out in send order: byte j of the frame payload sits
  // at snap[j*8 +: 8], each word zero-extended and emitted MSB-first.
  function automatic logic [SW-1:0] pack_snap(
    input logic [CH_NUM*POS_W-1:0]  p,
    input logic [CH_NUM*DIFF_W-1:0] d
  );
    logic [SW-1:0]   r;
    logic [PB*8-1:0] px;
    logic [DB*8-1:0] dx;
    r = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      px = '0;
      px[POS_W-1:0] = p[k*POS_W +: POS_W];
      dx = '0;
      dx[DIFF_W-1:0] = d[k*DIFF_W +: DIFF_W];
      for (int b = 0; b < PB; b++)
        r[(k*CB+b)*8 +: 8] = px[(PB-1-b)*8 +: 8];
      for (int b = 0; b < DB; b++)
        r[(k*CB+PB+b)*8 +: 8] = dx[(DB-1-b)*8 +: 8];
    end
    return r;
  endfunction

  // rdy_q marks when s2_q holds a real post-reset sample; arm_q then
  // requires a low level first so a vsync already high at release
  // cannot look like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      rdy_q <= 2'b00;
      arm_q <= 1'b0;
    end else begin
      s1_q  <= vsync_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      rdy_q <= {rdy_q[0], 1'b1};
      arm_q <= arm_q | (rdy_q[1] & ~s2_q);
    end
  end

  assign edge_w = s2_q & ~s3_q & arm_q;
  assign trig_w = edge_w & uart_en & (state_q == IDLE);
  assign add_en = (idx_q >= IW'(2)) && (idx_q <= IW'(LEN-2));

  always_comb begin
    didx   = idx_q - IW'(4);
    byte_d = sum_q;
    unique case (1'b1)
      idx_q == IW'(0): byte_d = HDR0;
      idx_q == IW'(1): byte_d = HDR1;
      idx_q == IW'(2): byte_d = seq_q;
      idx_q == IW'(3): byte_d = 8'(CH_NUM);
      (idx_q >= IW'(4)) && (idx_q < IW'(LEN-1)):
        byte_d = snap_q[didx*8 +: 8];
      default: byte_d = sum_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      sum_q   <= 8'h00;
      seq_q   <= 8'h00;
      idx_q   <= '0;
      to_q    <= 2'd0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      fb_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      txen_q <= 1'b0;
      ovr_q  <= edge_w & uart_en & (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (trig_w) begin
            snap_q  <= pack_snap(pos_i, diff_i);
            seq_q   <= seq_q + 8'd1;
            idx_q   <= '0;
            sum_q   <= 8'h00;
            fb_q    <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          txd_q <= byte_d;
          if (add_en)
            sum_q <= sum_q + byte_d;
          state_q <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            txen_q  <= 1'b1;
            to_q    <= 2'd0;
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // a transmitter that never raises busy is released after 4 cycles
          if (tx_busy || to_q == 2'd3)
            state_q <= WAIT_LO;
          else
            to_q <= to_q + 2'd1;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx_q == IW'(LEN-1)) begin
              fb_q    <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = txd_q;
  assign tx_en      = txen_q;
  assign frame_busy = fb_q;
  assign overrun    = ovr_q;
  assign seq_o      = seq_q;

endmodule

// File: tb/tb_uart_target_framer.sv
// Bench for uart_target_framer: default instance plus a 4-channel
// 16/8-bit instance, both checked against a frame-level reference model.
module tb_uart_target_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        uart_en;
  logic        vsync;
  logic [63:0] pa [4];
  logic [63:0] da [4];

  logic [85:0] pos_a;
  logic [23:0] diff_a;
  logic [63:0] pos_b;
  logic [31:0] diff_b;

  always_comb begin
    pos_a  = {pa[1][42:0], pa[0][42:0]};
    diff_a = {da[1][11:0], da[0][11:0]};
    pos_b  = {pa[3][15:0], pa[2][15:0], pa[1][15:0], pa[0][15:0]};
    diff_b = {da[3][7:0], da[2][7:0], da[1][7:0], da[0][7:0]};
  end

  logic       busy_a, busy_b;
  logic [7:0] txd_a, txd_b, seq_a, seq_b;
  logic       txen_a, txen_b, fb_a, fb_b, ov_a, ov_b;

  uart_target_framer dut_a (
    .clk(clk), .reset(rst_n), .uart_en(uart_en), .vsync_i(vsync),
    .pos_i(pos_a), .diff_i(diff_a), .tx_busy(busy_a),
    .tx_data(txd_a), .tx_en(txen_a), .frame_busy(fb_a),
    .overrun(ov_a), .seq_o(seq_a)
  );

  uart_target_framer #(.CH_NUM(4), .POS_W(16), .DIFF_W(8)) dut_b (
    .clk(clk), .reset(rst_n), .uart_en(uart_en), .vsync_i(vsync),
    .pos_i(pos_b), .diff_i(diff_b), .tx_busy(busy_b),
    .tx_data(txd_b), .tx_en(txen_b), .frame_busy(fb_b),
    .overrun(ov_b), .seq_o(seq_b)
  );

  // transmitter models and byte capture
  logic       busy_mode = 1'b1;
  int         bc_a = 0, bc_b = 0, cyc = 0, ova = 0, ovb = 0;
  logic [7:0] qa[$], qb[$], exp_a[$], exp_b[$];
  int         ta[$], tb[$];

  assign busy_a = (bc_a != 0);
  assign busy_b = (bc_b != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txen_a) begin
      qa.push_back(txd_a);
      ta.push_back(cyc);
      if (busy_mode) bc_a <= 10;
    end else if (bc_a > 0) bc_a <= bc_a - 1;
    if (txen_b) begin
      qb.push_back(txd_b);
      tb.push_back(cyc);
      if (busy_mode) bc_b <= 10;
    end else if (bc_b > 0) bc_b <= bc_b - 1;
    if (ov_a) ova <= ova + 1;
    if (ov_b) ovb <= ovb + 1;
  end

  int         total = 0, passed = 0;
  logic [7:0] seq_m;

  // reference frame: headers, seq, channel count, words MSB-first, sum
  function automatic void build(int w, logic [7:0] sq);
    int ch = w ? 4 : 2;
    int pw = w ? 16 : 43;
    int dw = w ? 8 : 12;
    int pb = (pw + 7) / 8;
    int db = (dw + 7) / 8;
    logic [63:0] v;
    logic [7:0]  s;
    logic [7:0]  fr[$];
    fr.push_back(8'hA5);
    fr.push_back(8'h5A);
    fr.push_back(sq);
    fr.push_back(8'(ch));
    for (int k = 0; k < ch; k++) begin
      v = pa[k] & ((64'd1 << pw) - 64'd1);
      for (int b = 0; b < pb; b++) fr.push_back(8'(v >> (8*(pb-1-b))));
      v = da[k] & ((64'd1 << dw) - 64'd1);
      for (int b = 0; b < db; b++) fr.push_back(8'(v >> (8*(db-1-b))));
    end
    s = 8'h00;
    for (int i = 2; i < fr.size(); i++) s = s + fr[i];
    fr.push_back(s);
    if (w != 0) exp_b = fr;
    else exp_a = fr;
  endfunction

  function automatic int first_bad(int w);
    int n = (w != 0) ? qb.size() : qa.size();
    int m = (w != 0) ? exp_b.size() : exp_a.size();
    for (int i = 0; i < n && i < m; i++)
      if (((w != 0) ? qb[i] : qa[i]) !== ((w != 0) ? exp_b[i] : exp_a[i]))
        return i;
    if (n != m) return (n < m) ? n : m;
    return -1;
  endfunction

  task automatic clr();
    qa.delete(); qb.delete(); ta.delete(); tb.delete();
    ova = 0; ovb = 0;
  endtask

  task automatic pulse();
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((fb_a || fb_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (fb_a || fb_b) $display("FAIL %s idle timeout fb_a=%b fb_b=%b", nm, fb_a, fb_b);
    else passed++;
  endtask

  task automatic wait_bytes(string nm, int k);
    int n = 0;
    while (qa.size() < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (qa.size() < k) $display("FAIL %s byte wait got %0d want %0d", nm, qa.size(), k);
    else passed++;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 4; k++) begin
      pa[k] = {$urandom, $urandom};
      da[k] = {$urandom, $urandom};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_en = 1'b1; vsync = 1'b1;
    rand_inputs();
    repeat (3) @(negedge clk);
    total++;
    if ({txen_a, txd_a, fb_a, ov_a, seq_a} !== 19'd0)
      $display("FAIL reset_a outputs got %h want 0", {txen_a, txd_a, fb_a, ov_a, seq_a});
    else passed++;
    total++;
    if ({txen_b, txd_b, fb_b, ov_b, seq_b} !== 19'd0)
      $display("FAIL reset_b outputs got %h want 0", {txen_b, txd_b, fb_b, ov_b, seq_b});
    else passed++;
    rst_n = 1'b1;
    seq_m = 8'h00;
    repeat (20) @(negedge clk);
    total++;
    if (qa.size() != 0 || fb_a || fb_b)
      $display("FAIL release_high bytes got %0d busy %b want 0", qa.size(), fb_a);
    else passed++;
  endtask

  task automatic test_single();
    int bad;
    logic [7:0] s;
    pa[0] = 64'h123_4567_89AB; pa[1] = 64'h0;
    da[0] = 64'hABC; da[1] = 64'h001;
    pa[2] = 64'h1234; pa[3] = 64'hBEEF;
    da[2] = 64'h7F; da[3] = 64'h80;
    seq_m = seq_m + 8'd1;
    build(0, seq_m); build(1, seq_m);
    clr();
    pulse();
    wait_idle("single");
    bad = first_bad(0);
    total++;
    if (bad != -1)
      $display("FAIL single_a byte %0d got %h want %h len %0d", bad, qa[bad], exp_a[bad], qa.size());
    else passed++;
    bad = first_bad(1);
    total++;
    if (bad != -1)
      $display("FAIL single_b byte %0d got %h want %h len %0d", bad, qb[bad], exp_b[bad], qb.size());
    else passed++;
    total++;
    if (qa.size() != 21 || qb.size() != 17)
      $display("FAIL frame_len got %0d/%0d want 21/17", qa.size(), qb.size());
    else passed++;
    s = 8'h00;
    for (int i = 2; i < 20 && i < qa.size(); i++) s = s + qa[i];
    total++;
    if (qa.size() != 21 || qa[20] !== s)
      $display("FAIL checksum got %h want %h", qa[20], s);
    else passed++;
    total++;
    if (seq_a !== 8'h01)
      $display("FAIL seq_first got %h want 01", seq_a);
    else passed++;
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 3; it++) begin
      rand_inputs();
      seq_m = seq_m + 8'd1;
      build(0, seq_m); build(1, seq_m);
      clr();
      pulse();
      rand_inputs();
      wait_idle("random");
      bad = first_bad(0);
      total++;
      if (bad != -1)
        $display("FAIL random_a it %0d byte %0d got %h want %h", it, bad, qa[bad], exp_a[bad]);
      else passed++;
      bad = first_bad(1);
      total++;
      if (bad != -1)
        $display("FAIL random_b it %0d byte %0d got %h want %h", it, bad, qb[bad], exp_b[bad]);
      else passed++;
      total++;
      if (seq_a !== seq_m || seq_b !== seq_m)
        $display("FAIL random_seq got %h/%h want %h", seq_a, seq_b, seq_m);
      else passed++;
    end
  endtask

  task automatic test_overrun();
    int bad;
    rand_inputs();
    seq_m = seq_m + 8'd1;
    build(0, seq_m); build(1, seq_m);
    clr();
    pulse();
    wait_bytes("overrun", 5);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_idle("overrun");
    total++;
    if (ova != 1 || ovb != 1)
      $display("FAIL overrun_pulses got %0d/%0d want 1/1", ova, ovb);
    else passed++;
    bad = first_bad(0);
    total++;
    if (bad != -1)
      $display("FAIL overrun_frame byte %0d got %h want %h", bad, qa[bad], exp_a[bad]);
    else passed++;
    repeat (40) @(negedge clk);
    total++;
    if (qa.size() != 21 || qb.size() != 17 || fb_a)
      $display("FAIL overrun_no_second got %0d/%0d want 21/17", qa.size(), qb.size());
    else passed++;
  endtask

  task automatic test_gating();
    int bad;
    uart_en = 1'b0;
    clr();
    pulse();
    repeat (40) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0 || ova != 0 || fb_a)
      $display("FAIL gated got bytes %0d ov %0d want 0 0", qa.size(), ova);
    else passed++;
    uart_en = 1'b1;
    rand_inputs();
    seq_m = seq_m + 8'd1;
    build(0, seq_m);
    clr();
    pulse();
    wait_bytes("gating", 3);
    uart_en = 1'b0;
    wait_idle("gating");
    bad = first_bad(0);
    total++;
    if (bad != -1)
      $display("FAIL en_fall_frame byte %0d got %h want %h len %0d", bad, qa[bad], exp_a[bad], qa.size());
    else passed++;
    uart_en = 1'b1;
  endtask

  task automatic test_timeout();
    int bad, gaps;
    busy_mode = 1'b0;
    rand_inputs();
    seq_m = seq_m + 8'd1;
    build(0, seq_m); build(1, seq_m);
    clr();
    pulse();
    wait_idle("timeout");
    bad = first_bad(0);
    total++;
    if (bad != -1)
      $display("FAIL timeout_frame byte %0d got %h want %h", bad, qa[bad], exp_a[bad]);
    else passed++;
    bad = first_bad(1);
    total++;
    if (bad != -1)
      $display("FAIL timeout_frame_b byte %0d got %h want %h", bad, qb[bad], exp_b[bad]);
    else passed++;
    gaps = 0;
    for (int i = 1; i < ta.size(); i++)
      if (ta[i] - ta[i-1] != 7) gaps++;
    total++;
    if (gaps != 0 || ta.size() != 21)
      $display("FAIL timeout_spacing bad gaps %0d pulses %0d want 0 21", gaps, ta.size());
    else passed++;
    busy_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bad;
    rand_inputs();
    clr();
    pulse();
    wait_bytes("reset_mid", 10);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({txen_a, txd_a, fb_a, ov_a, seq_a} !== 19'd0)
      $display("FAIL reset_mid_a got %h want 0", {txen_a, txd_a, fb_a, ov_a, seq_a});
    else passed++;
    total++;
    if ({fb_b, seq_b, txd_b} !== 17'd0)
      $display("FAIL reset_mid_b got %h want 0", {fb_b, seq_b, txd_b});
    else passed++;
    clr();
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seq_m = 8'h00;
    repeat (30) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0)
      $display("FAIL aborted_bytes got %0d/%0d want 0", qa.size(), qb.size());
    else passed++;
    rand_inputs();
    seq_m = seq_m + 8'd1;
    build(0, seq_m);
    pulse();
    wait_idle("after_reset");
    bad = first_bad(0);
    total++;
    if (bad != -1)
      $display("FAIL after_reset_frame byte %0d got %h want %h", bad, qa[bad], exp_a[bad]);
    else passed++;
    total++;
    if (qa.size() < 3 || {qa[0], qa[1], qa[2]} !== 24'hA55A01)
      $display("FAIL after_reset_start got %0d bytes want A5 5A 01", qa.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_overrun();
    test_gating();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
